// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the off-chip main-memory model that sits below the
// data cache.
//   state_t        - access FSM encoding (IDLE / BUSY / ACK, 2 bits)
//   MEM_LINE_BITS  - width of one memory line (one cache block)
//   OFFSET_BITS    - byte-offset bits inside a line, ignored for indexing
//   index_width()  - number of line-index bits for a given line count
// ---------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int MEM_LINE_BITS = 256;
  localparam int OFFSET_BITS   = 5;

  // log2 of the line count; a single-line memory still gets one index bit
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// ---------------------------------------------------------------------------
// mem_line_array
// Single-port DEPTH x LINE_BITS line store. Writes happen on the rising edge
// when we_i is high; the read port is combinational so the controller can
// capture the addressed line in the same edge that completes an access.
// Contents are never reset.
//   clk_i    - clock, rising edge
//   we_i     - write enable
//   index_i  - line index
//   wdata_i  - line to write
//   rdata_o  - line currently stored at index_i
// ---------------------------------------------------------------------------
module mem_line_array #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int IDX_W     = 9
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     index_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[index_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[index_i];

endmodule

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Main-memory model downstream of the data cache. Serves whole-line reads and
// writes after a fixed LATENCY and signals completion with a one-cycle ack.
//   clk_i     - clock, rising edge
//   rst_i     - synchronous reset, active low
//   addr_i    - byte address; bits [4:0] ignored, upper bits wrap mod DEPTH
//   data_i    - line to store on a write
//   enable_i  - request valid, held by the requester until ack_o
//   write_i   - 1 = write, 0 = read, sampled with enable_i
//   ack_o     - one-cycle completion pulse (high iff FSM is in ACK)
//   data_o    - last line read; valid in the ack cycle and held afterwards
// ---------------------------------------------------------------------------
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LINE_BITS  = MEM_LINE_BITS,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_BITS-1:0]  data_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  output logic                  ack_o,
  output logic [LINE_BITS-1:0]  data_o
);

  localparam int IDX_W = index_width(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_index;
  logic [LINE_BITS-1:0] r_wdata;
  logic                 r_write;
  logic [LINE_BITS-1:0] r_data_o;
  logic                 w_access;
  logic                 w_we;
  logic [LINE_BITS-1:0] w_rdata;
  logic                 w_unused_addr;

  // Byte offset and address bits above the index do not select a line.
  assign w_unused_addr = ^{addr_i[ADDR_WIDTH-1:OFFSET_BITS+IDX_W],
                           addr_i[OFFSET_BITS-1:0]};

  // The access fires on the last BUSY edge. The write is gated by reset so
  // an in-flight write aborted by reset never reaches the array.
  assign w_access = (r_state == BUSY) && (r_cnt == CNT_LAST);
  assign w_we     = w_access && r_write && rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: inputs only matter in IDLE; ACK always lasts one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_next_state = BUSY;
      BUSY:    if (w_access) w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request latching, latency counter and read-data capture
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_index  <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_data_o <= '0;
    end else begin
      if (r_state == IDLE && enable_i) begin
        r_index <= addr_i[OFFSET_BITS +: IDX_W];
        r_wdata <= data_i;
        r_write <= write_i;
        r_cnt   <= '0;
      end else if (r_state == BUSY && !w_access) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_access && !r_write) begin
        r_data_o <= w_rdata;
      end
    end
  end

  mem_line_array #(
    .LINE_BITS (LINE_BITS),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .index_i (r_index),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  assign ack_o  = (r_state == ACK);
  assign data_o = r_data_o;

endmodule

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory. A line-level reference memory (an
// associative array keyed by line number) predicts read data; latency and
// ack width are predicted from the LATENCY parameter.
// ---------------------------------------------------------------------------
module tb_data_memory;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic         clk;
  logic         rst_n;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] rdata;

  int n_vec  = 0;
  int n_fail = 0;

  logic [255:0] model_mem [int];
  logic [255:0] model_q;

  data_memory #(
    .LINE_BITS  (256),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .addr_i   (addr),
    .data_i   (wdata),
    .enable_i (enable),
    .write_i  (write),
    .ack_o    (ack),
    .data_o   (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // advance one clock and settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request and report what the DUT did. cycles counts edges from
  // the accepting edge (1) to the edge after which ack is seen; -1 on timeout.
  task automatic do_access(input bit wr, input logic [31:0] a,
                           input logic [255:0] d, input bit scramble,
                           output int cycles, output logic [255:0] q_ack,
                           output logic ack_after);
    enable = 1'b1; write = wr; addr = a; wdata = d;
    cycles = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (ack === 1'b1) begin
        cycles = n;
        break;
      end
      if (scramble) begin
        addr  = (a ^ 32'h20) ^ ($urandom & 32'hFFFF_C01F);
        wdata = rand_line();
        write = 1'($urandom);
      end
    end
    q_ack  = rdata;
    enable = 1'b0; write = 1'b0;
    step();
    ack_after = ack;
    if (cycles > 0) begin
      if (wr) model_mem[line_of(a)] = d;
      else    model_q = model_mem.exists(line_of(a)) ? model_mem[line_of(a)] : 'x;
    end
  endtask

  task automatic test_reset();
    int cyc; logic [255:0] q; logic aa; logic [255:0] d0;
    d0 = rand_line();
    rst_n = 1'b0; enable = 1'b1; write = 1'b1; addr = 32'h20; wdata = d0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack: got %b, expected 0", ack); end
      n_vec++;
      if (rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %h, expected 0", rdata); end
    end
    rst_n = 1'b1;
    model_q = '0;
    do_access(1'b1, 32'h20, d0, 1'b0, cyc, q, aa);
    n_vec++;
    if (cyc !== LAT + 1) begin n_fail++; $display("[TB] FAIL reset_first_ack: got %0d cycles, expected %0d", cyc, LAT + 1); end
  endtask

  task automatic test_read();
    int cyc; logic [255:0] q; logic aa;
    do_access(1'b1, 32'h60, {8{32'hDEADBEEF}}, 1'b0, cyc, q, aa);
    do_access(1'b0, 32'h60, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (cyc !== LAT + 1) begin n_fail++; $display("[TB] FAIL read_latency: got %0d, expected %0d", cyc, LAT + 1); end
    n_vec++;
    if (aa !== 1'b0) begin n_fail++; $display("[TB] FAIL read_ack_width: ack after pulse %b, expected 0", aa); end
    n_vec++;
    if (q !== {8{32'hDEADBEEF}}) begin n_fail++; $display("[TB] FAIL read_data: got %h, expected %h", q, {8{32'hDEADBEEF}}); end
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (rdata !== model_q) begin n_fail++; $display("[TB] FAIL read_hold: got %h, expected %h", rdata, model_q); end
  endtask

  task automatic test_write_read();
    int cyc; logic [255:0] q; logic aa;
    do_access(1'b1, 32'h80, {8{32'h12345678}}, 1'b0, cyc, q, aa);
    n_vec++;
    if (q !== model_q) begin n_fail++; $display("[TB] FAIL write_ack_data: got %h, expected %h", q, model_q); end
    n_vec++;
    if (cyc !== LAT + 1) begin n_fail++; $display("[TB] FAIL write_latency: got %0d, expected %0d", cyc, LAT + 1); end
    do_access(1'b0, 32'h80, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (q !== {8{32'h12345678}}) begin n_fail++; $display("[TB] FAIL write_read_data: got %h, expected %h", q, {8{32'h12345678}}); end
  endtask

  task automatic test_wrap();
    int cyc; logic [255:0] q; logic aa; logic [255:0] la;
    la = rand_line();
    do_access(1'b1, 32'h0000_0004, la, 1'b0, cyc, q, aa);
    do_access(1'b0, 32'h0000_4000, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (q !== la) begin n_fail++; $display("[TB] FAIL wrap_data: got %h, expected %h", q, la); end
  endtask

  task automatic test_mid_change();
    int cyc; logic [255:0] q; logic aa; logic [255:0] dx, dy;
    dx = rand_line(); dy = rand_line();
    do_access(1'b1, 32'h1A0, dy, 1'b0, cyc, q, aa);
    do_access(1'b1, 32'h180, dx, 1'b1, cyc, q, aa);
    n_vec++;
    if (cyc !== LAT + 1) begin n_fail++; $display("[TB] FAIL midchg_latency: got %0d, expected %0d", cyc, LAT + 1); end
    do_access(1'b0, 32'h180, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (q !== dx) begin n_fail++; $display("[TB] FAIL midchg_target: got %h, expected %h", q, dx); end
    do_access(1'b0, 32'h1A0, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (q !== dy) begin n_fail++; $display("[TB] FAIL midchg_other: got %h, expected %h", q, dy); end
  endtask

  task automatic test_reset_mid_write();
    int cyc; logic [255:0] q; logic aa; logic [255:0] old_l; bit seen;
    old_l = rand_line();
    do_access(1'b1, 32'hE0, old_l, 1'b0, cyc, q, aa);
    enable = 1'b1; write = 1'b1; addr = 32'hE0; wdata = ~old_l;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack === 1'b1) seen = 1'b1;
    end
    enable = 1'b0; write = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_q = '0;
    n_vec++;
    if (rdata !== model_q) begin n_fail++; $display("[TB] FAIL abort_data_clear: got %h, expected 0", rdata); end
    for (int i = 0; i < 15; i++) begin
      if (ack === 1'b1) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_ack: ack seen %b, expected 0", seen); end
    do_access(1'b0, 32'hE0, '0, 1'b0, cyc, q, aa);
    n_vec++;
    if (cyc !== LAT + 1) begin n_fail++; $display("[TB] FAIL abort_next_latency: got %0d, expected %0d", cyc, LAT + 1); end
    n_vec++;
    if (q !== old_l) begin n_fail++; $display("[TB] FAIL abort_line_kept: got %h, expected %h", q, old_l); end
  endtask

  task automatic test_random();
    int cyc; logic [255:0] q; logic aa; logic [255:0] prev_q;
    logic [31:0] a; int ln; bit wr;
    for (int it = 0; it < 24; it++) begin
      ln = 16 + int'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_C01F) | (32'(ln) << 5);
      wr = !model_mem.exists(ln) || ($urandom_range(0, 1) == 1);
      prev_q = model_q;
      do_access(wr, a, rand_line(), 1'b0, cyc, q, aa);
      n_vec++;
      if (cyc !== LAT + 1 || aa !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rand_timing[%0d]: got %0d cycles ack_after=%b, expected %0d cycles ack_after=0", it, cyc, aa, LAT + 1);
      end
      n_vec++;
      if (q !== (wr ? prev_q : model_mem[ln])) begin
        n_fail++;
        $display("[TB] FAIL rand_data[%0d]: got %h, expected %h", it, q, wr ? prev_q : model_mem[ln]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    model_q = '0;
    test_reset();
    test_read();
    test_write_read();
    test_wrap();
    test_mid_change();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
